// File: rtl/lamp_state_encoder.sv
// Scans a captured 16-bit lamp pattern one bit per cycle and reports the count.
// Optional thermometer checking is enabled with LAMP_STATE_STRICT_EN.
module lamp_state_encoder #(
    parameter int N_LAMPS = 16,
    parameter int CNT_W   = 4
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic [N_LAMPS-1:0] lights_state,
    output logic               busy,
    output logic               done,
    output logic [CNT_W-1:0]   active_lights,
    output logic               pattern_err
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SCAN = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(N_LAMPS - 1);

    state_t             state;
    state_t             state_nxt;
    logic [N_LAMPS-1:0] shreg;
    logic [CNT_W-1:0]   idx;
    logic [CNT_W:0]     run_cnt;
    logic [CNT_W:0]     run_nxt;
    logic               run_inc;
    logic               err_nxt;
    logic               bit_cur;
    logic               last_bit;
    logic               accept;
    logic               finish;

    assign bit_cur  = shreg[0];
    assign last_bit = (idx == LAST_IDX);
    assign accept   = start && (state == IDLE || state == DONE);
    assign finish   = (state == SCAN) && last_bit;

`ifdef LAMP_STATE_STRICT_EN
    logic seen_zero;
    logic err;

    // Thermometer tracking: count leading ones, flag any one after a zero.
    always_comb begin
        run_inc = bit_cur & ~seen_zero;
        err_nxt = err | (bit_cur & seen_zero) | (last_bit & bit_cur);
        run_nxt = run_cnt + {{CNT_W{1'b0}}, run_inc};
    end

    // Gap-detection flags, cleared on every accepted capture.
    always_ff @(posedge clk) begin
        if (reset) begin
            seen_zero <= 1'b0;
            err       <= 1'b0;
        end else if (accept) begin
            seen_zero <= 1'b0;
            err       <= 1'b0;
        end else if (state == SCAN) begin
            seen_zero <= seen_zero | ~bit_cur;
            err       <= err_nxt;
        end
    end

    // Error result is latched together with the count.
    always_ff @(posedge clk) begin
        if (reset)
            pattern_err <= 1'b0;
        else if (finish)
            pattern_err <= err_nxt;
    end
`else
    // Plain population count; no pattern checking.
    always_comb begin
        run_inc = bit_cur;
        err_nxt = 1'b0;
        run_nxt = run_cnt + {{CNT_W{1'b0}}, run_inc};
    end

    assign pattern_err = 1'b0;
`endif

    // State register.
    always_ff @(posedge clk) begin
        if (reset)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    // Next-state logic; start is only honoured in IDLE or DONE.
    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE:    state_nxt = accept ? SCAN : IDLE;
            SCAN:    state_nxt = last_bit ? DONE : SCAN;
            DONE:    state_nxt = start ? SCAN : IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Handshake outputs decoded from state.
    always_comb begin
        busy = (state == SCAN);
        done = (state == DONE);
    end

    // Shift register, scan index and run counter.
    always_ff @(posedge clk) begin
        if (reset) begin
            shreg   <= '0;
            idx     <= '0;
            run_cnt <= '0;
        end else if (accept) begin
            shreg   <= lights_state;
            idx     <= '0;
            run_cnt <= '0;
        end else if (state == SCAN) begin
            shreg   <= shreg >> 1;
            idx     <= idx + 1'b1;
            run_cnt <= run_nxt;
        end
    end

    // Count result, saturated when all lamps are lit.
    always_ff @(posedge clk) begin
        if (reset)
            active_lights <= '0;
        else if (finish)
            active_lights <= run_nxt[CNT_W] ? '1 : run_nxt[CNT_W-1:0];
    end

endmodule

// File: tb/tb_lamp_state_encoder.sv
// Scoreboard bench for lamp_state_encoder.
// Expected results come from a reference model of the lamp count.
module tb_lamp_state_encoder;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [15:0] lights_state;
    logic        busy;
    logic        done;
    logic [3:0]  active_lights;
    logic        pattern_err;

    int n_cmp = 0;
    int n_bad = 0;
    int overlap = 0;
    logic [4:0] sb_q[$];

    lamp_state_encoder #(.N_LAMPS(16), .CNT_W(4)) dut (
        .clk(clk),
        .reset(reset),
        .start(start),
        .lights_state(lights_state),
        .busy(busy),
        .done(done),
        .active_lights(active_lights),
        .pattern_err(pattern_err)
    );

    always #5 clk = ~clk;

    always @(negedge clk)
        if (busy && done) overlap++;

    task automatic chk(input string tag, input int got, input int exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)",
                     tag, got, got, exp, exp);
        end
    endtask

    // Reference model: returns {pattern_err, active_lights}.
    function automatic logic [4:0] model(input logic [15:0] p);
        int c;
        logic e;
        c = 0;
        e = 1'b0;
`ifdef LAMP_STATE_STRICT_EN
        while (c < 16 && p[c]) c++;
        e = ((32'(p) >> c) != 0) || p[15];
`else
        c = $countones(p);
`endif
        if (c > 15) c = 15;
        return {e, 4'(c)};
    endfunction

    // Wait for done; count negedges from the one after start was set.
    // hit_at > 0 pulses start with hit_pat at that cycle of the scan.
    task automatic wait_done(input string tag, input int hold,
                             input int hit_at, input logic [15:0] hit_pat,
                             input int exp_lat);
        int k;
        logic [4:0] e;
        k = 0;
        do begin
            @(negedge clk);
            k++;
            if (k == 1 && hold == 0) start = 1'b0;
            if (hit_at > 0 && k == hit_at) begin
                start = 1'b1;
                lights_state = hit_pat;
            end
            if (hit_at > 0 && k == hit_at + 1) start = 1'b0;
        end while (!done && k < 40);
        chk({tag, "_lat"}, k, exp_lat);
        if (sb_q.size() == 0) begin
            chk({tag, "_sb_empty"}, 1, 0);
        end else begin
            e = sb_q.pop_front();
            chk({tag, "_count"}, int'(active_lights), int'(e[3:0]));
            chk({tag, "_err"}, int'(pattern_err), int'(e[4]));
        end
    endtask

    task automatic launch(input logic [15:0] p);
        @(negedge clk);
        start = 1'b1;
        lights_state = p;
        sb_q.push_back(model(p));
    endtask

    initial begin
        logic [15:0] p;
        int dcnt;
        reset = 1'b1;
        start = 1'b0;
        lights_state = '0;
        repeat (3) @(negedge clk);
        reset = 1'b0;

        // Idle after reset.
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            chk("idle_outputs", int'({busy, done, active_lights, pattern_err}), 0);
        end

        // Legal thermometer sweep.
        for (int k = 0; k < 16; k++) begin
            p = 16'((32'd1 << k) - 1);
            launch(p);
            wait_done($sformatf("thermo%0d", k), 0, 0, 16'h0, 17);
            chk($sformatf("thermo%0d_abs", k), int'(active_lights), k);
        end

        launch(16'h0105);
        wait_done("gap0105", 0, 0, 16'h0, 17);
`ifdef LAMP_STATE_STRICT_EN
        chk("gap0105_abs", int'({pattern_err, active_lights}), 5'h11);
`else
        chk("gap0105_abs", int'({pattern_err, active_lights}), 5'h03);
`endif

        launch(16'hFFFF);
        wait_done("full", 0, 0, 16'h0, 17);
`ifdef LAMP_STATE_STRICT_EN
        chk("full_abs", int'({pattern_err, active_lights}), 5'h1F);
`else
        chk("full_abs", int'({pattern_err, active_lights}), 5'h0F);
`endif

        // Start during scan is ignored; pattern change has no effect.
        launch(16'h00FF);
        wait_done("ignore", 0, 5, 16'h0001, 17);
        chk("ignore_abs", int'(active_lights), 8);

        // Start held through done restarts immediately.
        launch(16'h0007);
        wait_done("b2b_a", 1, 0, 16'h0, 17);
        lights_state = 16'h001F;
        sb_q.push_back(model(16'h001F));
        @(negedge clk);
        start = 1'b0;
        chk("b2b_busy_t18", int'({busy, done}), 2);
        wait_done("b2b_b", 0, 0, 16'h0, 16);
        chk("b2b_b_abs", int'(active_lights), 5);

        // Reset mid-scan aborts with no done.
        launch(16'h003F);
        dcnt = 0;
        for (int k = 1; k <= 8; k++) begin
            @(negedge clk);
            if (k == 1) start = 1'b0;
            if (done) dcnt++;
        end
        reset = 1'b1;
        void'(sb_q.pop_back());
        @(negedge clk);
        reset = 1'b0;
        chk("rst_outputs", int'({busy, done, active_lights, pattern_err}), 0);
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (done) dcnt++;
        end
        chk("rst_no_done", dcnt, 0);
        launch(16'h003F);
        wait_done("after_rst", 0, 0, 16'h0, 17);
        chk("after_rst_abs", int'(active_lights), 6);

        repeat (3) @(negedge clk);
        chk("busy_done_excl", overlap, 0);
        chk("sb_drained", sb_q.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
